// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: loads a word and shifts its low len bits out MSB-first, one per clock.
// Define SERIAL_PATTERN_TX_REPEAT_EN to add the repeat_mode input (gapless restart of the captured pattern).
module serial_pattern_tx #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1,
  localparam int  LW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LW-1:0]    len,
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
  input  logic             repeat_mode,
`endif
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SHIFT = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LW-1:0]    len_eff;
  logic [WIDTH-1:0] load_sel;
  logic [WIDTH-1:0] shift_sel;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
  logic [LW-1:0]    len_q, len_d;
  logic [WIDTH-1:0] rep_sel;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    len_eff = (len > WIDTH_L) ? WIDTH_L : len;
    // Bit selection by shifting keeps index widths independent of WIDTH.
    load_sel  = data_in >> (len_eff - ONE_L);
    shift_sel = shreg_q >> (cnt_q - ONE_L);
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
    len_d   = len_q;
    rep_sel = shreg_q >> (len_q - ONE_L);
`endif

    case (state_q)
      IDLE: begin
        out_d  = IDLE_LEVEL;
        busy_d = 1'b0;
        if (start && (len != '0)) begin
          shreg_d = data_in;
          out_d   = load_sel[0];
          cnt_d   = len_eff - ONE_L;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
          len_d   = len_eff;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          out_d = shift_sel[0];
          cnt_d = cnt_q - ONE_L;
        end else begin
          done_d = 1'b1;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
          if (repeat_mode) begin
            out_d = rep_sel[0];
            cnt_d = len_q - ONE_L;
          end else begin
            out_d   = IDLE_LEVEL;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`else
          out_d   = IDLE_LEVEL;
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      out_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
      len_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
      len_q   <= len_d;
`endif
    end
  end

  assign serial_out = out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
